// File: rtl/sample_history_buffer_pkg.sv
// Shared defaults, width helpers and circular tap addressing
// for the per-channel sample history buffer.
package sample_history_buffer_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_TAPS     = 64;
  localparam int DEF_CHANNELS = 2;

  typedef struct packed {
    logic valid;
    logic zero_a;
    logic zero_b;
  } rd_flags_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int chan_w(input int ch);
    return (ch > 1) ? clog2(ch) : 1;
  endfunction

  // (wp - 1 - k) mod taps without a divider; k outside the
  // history is folded to 0 since such reads are masked anyway
  function automatic int tap_addr(
    input int wp,
    input int k,
    input int taps
  );
    int kk;
    kk = (k < taps) ? k : 0;
    return (wp > kk) ? (wp - 1 - kk) : (wp + taps - 1 - kk);
  endfunction

endpackage

// File: rtl/sample_history_buffer_ram.sv
// Storage for all channel histories: one write port and
// two enabled, registered read ports; no reset.
module history_ram_1w2r
  import sample_history_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_TAPS * DEF_CHANNELS,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] q_a,
  input  logic              re_b,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re_a) q_a <= mem[raddr_a];
    if (re_b) q_b <= mem[raddr_b];
  end

endmodule

// File: rtl/sample_history_buffer.sv
// Multi-channel sample history with zero-padded tap reads
// and an optional mirror-tap port for symmetric filters.
module sample_history_buffer
  import sample_history_buffer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAPS      = DEF_TAPS,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int SYMMETRIC = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  input  logic [chan_w(CHANNELS)-1:0] s_chan,
  input  logic                        flush,
  input  logic [chan_w(CHANNELS)-1:0] flush_chan,
  input  logic                        rd_req,
  input  logic [chan_w(CHANNELS)-1:0] rd_chan,
  input  logic [clog2(TAPS+1)-1:0]    rd_tap,
  output logic [DATA_W-1:0]           rd_data,
  output logic [DATA_W-1:0]           rd_data_b,
  output logic                        rd_data_valid,
  output logic [clog2(TAPS+1)-1:0]    fill_level
);

  localparam int CW    = chan_w(CHANNELS);
  localparam int AW    = clog2(TAPS + 1);
  localparam int TW    = clog2(TAPS);
  localparam int DEPTH = CHANNELS * TAPS;
  localparam int RAW   = clog2(DEPTH);

  logic [1:0]          rdy_sr;
  logic [TW-1:0]       wp   [CHANNELS];
  logic [AW-1:0]       fill [CHANNELS];
  logic                we;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] fl_hit;
  logic [TW-1:0]       cur_wp;
  logic [TW-1:0]       rd_wp;
  logic [AW-1:0]       rd_fill;
  logic [AW-1:0]       kb;
  logic                zero_a_d;
  logic                zero_b_d;
  logic [RAW-1:0]      waddr;
  logic [RAW-1:0]      raddr_a;
  logic [RAW-1:0]      raddr_b;
  logic [DATA_W-1:0]   q_a;
  logic [DATA_W-1:0]   q_b;
  rd_flags_t           flg_q;

  // ready rises only after a full clean cycle out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_sr <= '0;
    else     rdy_sr <= {rdy_sr[0], 1'b1};
  end

  assign s_ready = rdy_sr[1];
  assign we      = s_valid && s_ready;

  always_comb begin
    wr_hit  = '0;
    fl_hit  = '0;
    cur_wp  = '0;
    rd_wp   = '0;
    rd_fill = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_hit[c] = we && (s_chan == CW'(c));
      fl_hit[c] = flush && (flush_chan == CW'(c));
      if (s_chan == CW'(c)) cur_wp = wp[c];
      if (rd_chan == CW'(c)) begin
        rd_wp   = wp[c];
        rd_fill = fill[c];
      end
    end
  end

  assign fill_level = rd_fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wp[c]   <= '0;
        fill[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_hit[c])
          wp[c] <= (wp[c] == TW'(TAPS - 1)) ? '0 : wp[c] + 1'b1;
        if (fl_hit[c])
          fill[c] <= wr_hit[c] ? AW'(1) : '0;
        else if (wr_hit[c] && fill[c] != AW'(TAPS))
          fill[c] <= fill[c] + 1'b1;
      end
    end
  end

  assign waddr = RAW'(int'(s_chan) * TAPS + int'(cur_wp));

  assign kb = AW'(TAPS - 1) - rd_tap;

  assign raddr_a = RAW'(int'(rd_chan) * TAPS +
    tap_addr(int'(rd_wp), int'(rd_tap), TAPS));

  assign raddr_b = RAW'(int'(rd_chan) * TAPS +
    tap_addr(int'(rd_wp), int'(kb), TAPS));

  // reads see the pre-write pointer and fill of this cycle
  assign zero_a_d = (rd_tap >= rd_fill);
  assign zero_b_d = (SYMMETRIC == 0) ||
                    (rd_tap >= AW'(TAPS)) ||
                    (kb >= rd_fill);

  history_ram_1w2r #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAW)
  ) u_ram (
    .clk     (clk),
    .we      (|wr_hit),
    .waddr   (waddr),
    .wdata   (s_data),
    .re_a    (rd_req),
    .raddr_a (raddr_a),
    .q_a     (q_a),
    .re_b    (rd_req && (SYMMETRIC != 0)),
    .raddr_b (raddr_b),
    .q_b     (q_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flg_q <= '{valid: 1'b0, zero_a: 1'b1, zero_b: 1'b1};
    end else begin
      flg_q.valid <= rd_req;
      if (rd_req) begin
        flg_q.zero_a <= zero_a_d;
        flg_q.zero_b <= zero_b_d;
      end
    end
  end

  assign rd_data       = flg_q.zero_a ? '0 : q_a;
  assign rd_data_b     = flg_q.zero_b ? '0 : q_b;
  assign rd_data_valid = flg_q.valid;

endmodule

// File: tb/tb_sample_history_buffer.sv
// Bench for sample_history_buffer: default, symmetric TAPS=8
// and TAPS=5 instances, scoreboarded tap reads.
module tb_sample_history_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] d;
    logic [15:0] db;
  } exp_t;

  typedef struct {
    int ch;
    int k;
    int e;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  // DUT A: defaults (16b, 64 taps, 2 channels)
  logic        sv_a, rdy_a, fl_a, rq_a, rv_a;
  logic [15:0] sd_a, rd_a, rdb_a;
  logic [0:0]  sc_a, flc_a, rc_a;
  logic [6:0]  rt_a, fill_a;

  // DUT B: symmetric, 8 taps, 1 channel
  logic        sv_b, rdy_b, fl_b, rq_b, rv_b;
  logic [15:0] sd_b, rd_b, rdb_b;
  logic [0:0]  sc_b, flc_b, rc_b;
  logic [3:0]  rt_b, fill_b;

  // DUT C: 5 taps, 2 channels
  logic        sv_c, rdy_c, fl_c, rq_c, rv_c;
  logic [15:0] sd_c, rd_c, rdb_c;
  logic [0:0]  sc_c, flc_c, rc_c;
  logic [2:0]  rt_c, fill_c;

  sample_history_buffer u_a (
    .clk(clk), .rst(rst),
    .s_valid(sv_a), .s_ready(rdy_a), .s_data(sd_a), .s_chan(sc_a),
    .flush(fl_a), .flush_chan(flc_a),
    .rd_req(rq_a), .rd_chan(rc_a), .rd_tap(rt_a),
    .rd_data(rd_a), .rd_data_b(rdb_a), .rd_data_valid(rv_a),
    .fill_level(fill_a)
  );

  sample_history_buffer #(
    .TAPS(8), .CHANNELS(1), .SYMMETRIC(1)
  ) u_b (
    .clk(clk), .rst(rst),
    .s_valid(sv_b), .s_ready(rdy_b), .s_data(sd_b), .s_chan(sc_b),
    .flush(fl_b), .flush_chan(flc_b),
    .rd_req(rq_b), .rd_chan(rc_b), .rd_tap(rt_b),
    .rd_data(rd_b), .rd_data_b(rdb_b), .rd_data_valid(rv_b),
    .fill_level(fill_b)
  );

  sample_history_buffer #(
    .TAPS(5), .CHANNELS(2)
  ) u_c (
    .clk(clk), .rst(rst),
    .s_valid(sv_c), .s_ready(rdy_c), .s_data(sd_c), .s_chan(sc_c),
    .flush(fl_c), .flush_chan(flc_c),
    .rd_req(rq_c), .rd_chan(rc_c), .rd_tap(rt_c),
    .rd_data(rd_c), .rd_data_b(rdb_c), .rd_data_valid(rv_c),
    .fill_level(fill_c)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int d, input int db);
    exp_t x;
    x.d  = 16'(d);
    x.db = 16'(db);
    return x;
  endfunction

  always @(negedge clk) begin
    if (rv_a) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_rd_data", int'(rd_a), int'(ea.d));
        chk("a_rd_data_b", int'(rdb_a), int'(ea.db));
      end
    end
    if (rv_b) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_rd_data", int'(rd_b), int'(eb.d));
        chk("b_rd_data_b", int'(rdb_b), int'(eb.db));
      end
    end
    if (rv_c) begin
      if (qc.size() == 0) chk("c_unexpected_valid", 1, 0);
      else begin
        ec = qc.pop_front();
        chk("c_rd_data", int'(rd_c), int'(ec.d));
        chk("c_rd_data_b", int'(rdb_c), int'(ec.db));
      end
    end
  end

  task automatic wr_a(input int ch, input int d);
    sv_a = 1'b1; sc_a = 1'(ch); sd_a = 16'(d);
    @(posedge clk); #1;
    sv_a = 1'b0;
  endtask

  task automatic rd_a_t(input int ch, input int k, input int e);
    rq_a = 1'b1; rc_a = 1'(ch); rt_a = 7'(k);
    qa.push_back(mk(e, 0));
    @(posedge clk); #1;
    rq_a = 1'b0;
  endtask

  task automatic wr_b(input int d);
    sv_b = 1'b1; sc_b = 1'b0; sd_b = 16'(d);
    @(posedge clk); #1;
    sv_b = 1'b0;
  endtask

  task automatic rd_b_t(input int k, input int e, input int eb2);
    rq_b = 1'b1; rc_b = 1'b0; rt_b = 4'(k);
    qb.push_back(mk(e, eb2));
    @(posedge clk); #1;
    rq_b = 1'b0;
  endtask

  task automatic wr_c(input int ch, input int d);
    sv_c = 1'b1; sc_c = 1'(ch); sd_c = 16'(d);
    @(posedge clk); #1;
    sv_c = 1'b0;
  endtask

  task automatic rd_c_t(input int ch, input int k, input int e);
    rq_c = 1'b1; rc_c = 1'(ch); rt_c = 3'(k);
    qc.push_back(mk(e, 0));
    @(posedge clk); #1;
    rq_c = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t va [10];
    int   hc0[$];
    int   hc1[$];
    int   n;
    int   tmp;

    va[0] = '{0, 0, 70};
    va[1] = '{0, 5, 65};
    va[2] = '{0, 63, 7};
    va[3] = '{0, 1, 69};
    va[4] = '{0, 64, 0};
    va[5] = '{0, 127, 0};
    va[6] = '{1, 3, 0};
    va[7] = '{1, 2, 100};
    va[8] = '{1, 0, 300};
    va[9] = '{1, 1, 200};

    {sv_a, fl_a, rq_a, sd_a, sc_a, flc_a, rc_a, rt_a} = '0;
    {sv_b, fl_b, rq_b, sd_b, sc_b, flc_b, rc_b, rt_b} = '0;
    {sv_c, fl_c, rq_c, sd_c, sc_c, flc_c, rc_c, rt_c} = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_a", int'(rdy_a), 0);
    chk("rst_valid_a", int'(rv_a), 0);
    chk("rst_data_a", int'(rd_a), 0);
    chk("rst_fill_a", int'(fill_a), 0);
    chk("rst_ready_b", int'(rdy_b), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_low_after_rst", int'(rdy_a), 0);
    n = 0;
    while (!(rdy_a && rdy_b && rdy_c) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", int'(rdy_a && rdy_b && rdy_c), 1);

    // DUT A: fill past saturation, then a short second channel
    for (int i = 1; i <= 70; i++) wr_a(0, i);
    rc_a = 1'b0; #1;
    chk("a_fill_ch0_sat", int'(fill_a), 64);
    wr_a(1, 100); wr_a(1, 200); wr_a(1, 300);
    rc_a = 1'b1; #1;
    chk("a_fill_ch1", int'(fill_a), 3);

    for (int i = 0; i < 10; i++) rd_a_t(va[i].ch, va[i].k, va[i].e);

    rd_a_t(0, 0, 70);
    @(posedge clk);
    @(negedge clk);
    chk("a_hold_valid", int'(rv_a), 0);
    chk("a_hold_data", int'(rd_a), 70);
    @(posedge clk); #1;

    // flush with simultaneous write
    fl_a = 1'b1; flc_a = 1'b0;
    sv_a = 1'b1; sc_a = 1'b0; sd_a = 16'h1234;
    @(posedge clk); #1;
    fl_a = 1'b0; sv_a = 1'b0;
    rc_a = 1'b0; #1;
    chk("a_fill_flush_wr", int'(fill_a), 1);
    rd_a_t(0, 0, 'h1234);
    rd_a_t(0, 1, 0);
    rd_a_t(0, 63, 0);
    rd_a_t(1, 0, 300);

    // flush alone on ch1
    fl_a = 1'b1; flc_a = 1'b1;
    @(posedge clk); #1;
    fl_a = 1'b0;
    rc_a = 1'b1; #1;
    chk("a_fill_ch1_flushed", int'(fill_a), 0);
    rd_a_t(1, 0, 0);

    // same-cycle read and write on ch0
    fl_a = 1'b1; flc_a = 1'b0;
    @(posedge clk); #1;
    fl_a = 1'b0;
    wr_a(0, 10); wr_a(0, 20);
    sv_a = 1'b1; sc_a = 1'b0; sd_a = 16'd30;
    rq_a = 1'b1; rc_a = 1'b0; rt_a = 7'd0;
    qa.push_back(mk(20, 0));
    @(posedge clk); #1;
    sv_a = 1'b0; rq_a = 1'b0;
    rd_a_t(0, 0, 30);
    rd_a_t(0, 2, 10);
    sv_a = 1'b1; sc_a = 1'b0; sd_a = 16'd40;
    rq_a = 1'b1; rc_a = 1'b0; rt_a = 7'd3;
    qa.push_back(mk(0, 0));
    @(posedge clk); #1;
    sv_a = 1'b0; rq_a = 1'b0;
    rd_a_t(0, 3, 10);
    rd_a_t(0, 0, 40);

    // DUT B: mirror taps, partial then full history
    wr_b(1); wr_b(2); wr_b(3);
    rd_b_t(0, 3, 0);
    rd_b_t(5, 0, 1);
    for (int i = 4; i <= 8; i++) wr_b(i);
    #1;
    chk("b_fill_full", int'(fill_b), 8);
    rd_b_t(1, 7, 2);
    rd_b_t(0, 8, 1);
    rd_b_t(7, 1, 8);
    rd_b_t(3, 5, 4);
    rd_b_t(8, 0, 0);
    wr_b(9);
    rd_b_t(0, 9, 2);

    // DUT C: non-power-of-two wrap against a recency model
    for (int i = 1; i <= 12; i++) begin
      wr_c(0, i * 7);
      hc0.push_front(i * 7);
      if (hc0.size() > 5) tmp = hc0.pop_back();
    end
    wr_c(1, 501); hc1.push_front(501);
    wr_c(1, 502); hc1.push_front(502);
    rc_c = 1'b0; #1;
    chk("c_fill_ch0", int'(fill_c), 5);
    rc_c = 1'b1; #1;
    chk("c_fill_ch1", int'(fill_c), 2);
    for (int k = 0; k < 8; k++)
      rd_c_t(0, k, (k < hc0.size()) ? hc0[k] : 0);
    for (int k = 0; k < 3; k++)
      rd_c_t(1, k, (k < hc1.size()) ? hc1[k] : 0);

    // reset lands on an in-flight read
    @(posedge clk); #1;
    rq_c = 1'b1; rc_c = 1'b0; rt_c = 3'd0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rq_c = 1'b0;
    chk("c_abort_valid", int'(rv_c), 0);
    chk("c_abort_data", int'(rd_c), 0);
    chk("c_rst_ready", int'(rdy_c), 0);
    rc_c = 1'b0; #1;
    chk("c_rst_fill0", int'(fill_c), 0);
    rc_c = 1'b1; #1;
    chk("c_rst_fill1", int'(fill_c), 0);
    rc_a = 1'b0; #1;
    chk("a_rst_fill0", int'(fill_a), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("c_ready_low_0", int'(rdy_c), 0);
    @(posedge clk); #1;
    chk("c_ready_low_1", int'(rdy_c), 0);
    @(posedge clk); #1;
    chk("c_ready_high", int'(rdy_c), 1);
    wr_c(0, 555);
    rd_c_t(0, 0, 555);
    rd_c_t(0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drain", qa.size() + qb.size() + qc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_history_buffer.md
SAMPLE_HISTORY_BUFFER -- requirements
Module: sample_history_buffer

Interface
REQ-001 Parameter DATA_W, default 16, signed sample width (Q1.15 at default).
REQ-002 Parameter TAPS, default 64, history depth per channel; any value 2..1024, not required to be a power of two.
REQ-003 Parameter CHANNELS, default 2, independent histories (e.g. stereo L/R); range 1..8.
REQ-004 Parameter SYMMETRIC, default 0; 1 enables the mirror-tap read port.
REQ-005 Derived widths: CW = max(1,clog2(CHANNELS)), AW = clog2(TAPS+1).
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 s_valid  in  1  input sample offered.
REQ-009 s_ready  out  1  block accepts a sample this cycle.
REQ-010 s_data  in  DATA_W  signed input sample.
REQ-011 s_chan  in  CW  channel of the input sample.
REQ-012 flush  in  1  clear history of flush_chan (single-cycle pulse).
REQ-013 flush_chan  in  CW  channel to flush.
REQ-014 rd_req  in  1  tap read request.
REQ-015 rd_chan  in  CW  channel to read.
REQ-016 rd_tap  in  AW  tap index k; 0 = newest sample.
REQ-017 rd_data  out  DATA_W  sample at tap k.
REQ-018 rd_data_b  out  DATA_W  sample at mirror tap TAPS-1-k (SYMMETRIC=1), else constant 0.
REQ-019 rd_data_valid  out  1  rd_data/rd_data_b valid this cycle.
REQ-020 fill_level  out  AW  number of valid samples in rd_chan's history (combinational from rd_chan).

Function
REQ-021 Write occurs when s_valid && s_ready; sample stored at channel s_chan write pointer, pointer advances by 1 and wraps from TAPS-1 to 0.
REQ-022 Per-channel fill counter increments on each write and saturates at TAPS.
REQ-023 s_ready SHALL be 0 during reset and the first cycle after rst deasserts, 1 thereafter; back-to-back writes every cycle are sustained.
REQ-024 Read address = (wp[rd_chan] - 1 - k) mod TAPS; mirror address uses k' = TAPS-1-k.
REQ-025 Read latency exactly 1 cycle: rd_data_valid is rd_req registered; data held until the next valid read.
REQ-026 A tap with k >= fill[rd_chan] or k >= TAPS SHALL return 0 (zero-padded history); same rule applies independently to the mirror tap.
REQ-027 Read and write to the same channel in the same cycle: read sees pre-write state (old pointer and fill).
REQ-028 Flush sets fill[flush_chan] to 0 without clearing storage or moving the pointer; takes effect the next cycle.
REQ-029 Flush and write to the same channel in the same cycle: fill becomes 1 and the written sample is tap 0.
REQ-030 Channels are fully independent; writes/flushes to one never alter another's taps.

Reset
REQ-031 rst clears all write pointers and fill counters to 0, rd_data, rd_data_b and rd_data_valid to 0, s_ready to 0; storage contents need not be cleared.
REQ-032 rst asserted mid-operation aborts any pending read (rd_data_valid 0 next edge) and discards in-flight writes.

Structure
REQ-033 Shared package holds default DATA_W/TAPS/CHANNELS values, clog2 helper and the mod-TAPS address function.
REQ-034 Storage in one sub-module history_ram_1w2r (CHANNELS*TAPS words, 1 write, 2 registered read ports, no reset), mappable to block RAM.

Verification
REQ-035 Reset, write 1..70 to ch0, read k=0,5,63 -> 70, 65, 7 one cycle after rd_req; fill_level=64.
REQ-036 Write 3 samples 100,200,300 to ch1, read k=3 -> 0; read k=2 -> 100; ch0 taps unaffected.
REQ-037 SYMMETRIC=1, TAPS=8, write 1..8, rd_tap=1 -> rd_data=7, rd_data_b=2.
REQ-038 Flush ch0 with simultaneous write 0x1234 -> fill_level=1, k=0 -> 0x1234, k=1 -> 0.
REQ-039 Read and write ch0 same cycle after samples 10,20 -> k=0 returns 20, next read returns new sample.
REQ-040 TAPS=5, write 12 samples (non-power-of-two wrap), assert rst mid-read -> rd_data_valid 0, all fills 0, s_ready low 2 cycles.
